// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch front end for the pipelined MIPS core.
// Owns the PC, issues in-order fetches on a req/gnt + rvalid bus, buffers
// returned words in a small prefetch queue and hands them to IF/ID with
// their PC and PC+4. A redirect flushes the queue and discards responses
// that are still outstanding.
module unidade_busca #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_mais_4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [31:0]       q_inst [DEPTH];
  logic [ADDR_W-1:0] tag    [DEPTH];
  logic [PW-1:0]     q_rd, q_wr, t_rd, t_wr;
  logic [CW-1:0]     q_count, inflight, drop;
  logic [CW+1:0]     used;
  logic              issue, resp_take, resp_any, pop;

  // Credit accounting, handshake decode and output selection.
  always_comb begin
    used      = {2'b00, q_count} + {2'b00, inflight} + {2'b00, drop};
    mem_req   = reset_n && !redirect && (used < (CW+2)'(DEPTH));
    mem_addr  = fetch_pc;
    issue     = mem_req && mem_gnt;
    resp_any  = mem_rvalid && (inflight != '0 || drop != '0);
    resp_take = mem_rvalid && !redirect && (drop == '0) && (inflight != '0);
    out_valid = (q_count != '0);
    pop       = out_valid && out_ready && !redirect;
    out_inst      = out_valid ? q_inst[q_rd] : '0;
    out_pc        = out_valid ? q_pc[q_rd] : '0;
    out_pc_mais_4 = out_valid ? q_pc[q_rd] + ADDR_W'(4) : '0;
  end

  // Control state: PC, queue/tag pointers and outstanding-response counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      q_rd     <= '0;
      q_wr     <= '0;
      q_count  <= '0;
      t_rd     <= '0;
      t_wr     <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still outstanding becomes stale; a response landing now
      // is one of those stale ones and is consumed here.
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      q_rd     <= '0;
      q_wr     <= '0;
      q_count  <= '0;
      t_rd     <= '0;
      t_wr     <= '0;
      inflight <= '0;
      drop     <= drop + inflight - CW'(resp_any);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        t_wr     <= t_wr + PW'(1);
      end
      if (resp_take) begin
        t_rd <= t_rd + PW'(1);
        q_wr <= q_wr + PW'(1);
      end
      if (pop) q_rd <= q_rd + PW'(1);
      q_count  <= q_count + CW'(resp_take) - CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(resp_take);
      if (mem_rvalid && drop != '0) drop <= drop - CW'(1);
    end
  end

  // Tag FIFO and prefetch queue storage; contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (issue) tag[t_wr] <= fetch_pc;
    if (resp_take) begin
      q_pc[q_wr]   <= tag[t_rd];
      q_inst[q_wr] <= mem_rdata;
    end
  end

  // A response with nothing outstanding is a memory-side protocol violation.
  always_ff @(posedge clock) begin
    if (reset_n) assert (!(mem_rvalid && inflight == '0 && drop == '0));
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: a behavioural memory plus a transaction-level
// model (expected fetch address, queue of delivered PCs, outstanding
// requests tagged with a redirect epoch) checked every cycle, and a few
// literal expectations for the scenarios of interest.
module tb_unidade_busca;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned ep;
  } req_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pc_mais_4;

  logic        req8, valid8;
  logic [7:0]  addr8, pc8, pc4_8;
  logic        rvalid8 = 1'b0;
  logic [31:0] rdata8 = '0;
  logic [31:0] inst8;

  always #5 clock = ~clock;

  unidade_busca #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc_mais_4(out_pc_mais_4));

  unidade_busca #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
    .clock(clock), .reset_n(reset_n), .redirect(1'b0), .redirect_pc(8'h00),
    .mem_req(req8), .mem_addr(addr8), .mem_gnt(1'b1), .mem_rvalid(rvalid8),
    .mem_rdata(rdata8), .out_valid(valid8), .out_ready(1'b1),
    .out_inst(inst8), .out_pc(pc8), .out_pc_mais_4(pc4_8));

  int unsigned n_cmp = 0, n_bad = 0;
  logic [31:0] q_pc[$];
  req_t        pend[$];
  logic [31:0] emitted[$];
  logic [31:0] exp_fetch = '0;
  int unsigned epoch = 0, cyc = 0, lat = 1, n_issue = 0;
  logic        n_rst = 1'b0, n_redirect = 1'b0, n_ready = 1'b0, n_gnt = 1'b0;
  logic [31:0] n_rpc = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // One clock: apply inputs, compare DUT to model, then advance the model.
  task automatic step();
    logic exp_req, exp_valid, rsp;
    req_t r;
    @(negedge clock);
    reset_n     = n_rst;
    redirect    = n_redirect;
    redirect_pc = n_rpc;
    out_ready   = n_ready;
    mem_gnt     = n_gnt;
    rsp         = n_rst && pend.size() > 0 && pend[0].due <= cyc;
    mem_rvalid  = rsp;
    mem_rdata   = rsp ? word_of(pend[0].addr) : $urandom;
    #1;
    exp_req   = reset_n && !redirect && (q_pc.size() + pend.size() < DEPTH);
    exp_valid = q_pc.size() > 0;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr, exp_fetch);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_inst", out_inst, word_of(q_pc[0]));
      chk("out_pc_mais_4", out_pc_mais_4, q_pc[0] + 32'd4);
    end
    if (!reset_n) begin
      q_pc.delete();
      pend.delete();
      exp_fetch = 32'h0;
      epoch++;
    end else begin
      if (exp_valid && out_ready && !redirect) emitted.push_back(q_pc.pop_front());
      if (rsp) begin
        r = pend.pop_front();
        if (!redirect && r.ep == epoch) q_pc.push_back(r.addr);
      end
      if (exp_req && mem_gnt) begin
        pend.push_back('{exp_fetch, cyc + lat, epoch});
        exp_fetch += 32'd4;
        n_issue++;
      end
      if (redirect) begin
        q_pc.delete();
        epoch++;
        exp_fetch = redirect_pc & ~32'h3;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int unsigned n);
    n_rst = 1'b0;
    repeat (n) step();
    n_rst = 1'b1;
  endtask

  task automatic expect_seq(input string name, input logic [31:0] base, input int unsigned n);
    if (emitted.size() < n) timeout(name);
    else for (int unsigned i = 0; i < n; i++) chk(name, emitted[i], base + 32'(4 * i));
  endtask

  // Narrow instance: 1-cycle memory, always ready; record its first outputs.
  logic        issued8 = 1'b0;
  logic [7:0]  last8 = '0;
  int unsigned cap8 = 0;
  logic [7:0]  pcs8[4];
  logic [7:0]  p48[4];
  logic [31:0] i8[4];
  initial forever begin
    @(negedge clock);
    rvalid8 = issued8;
    rdata8  = {24'h5EED00, last8};
    #1;
    issued8 = req8;
    last8   = addr8;
    if (reset_n && valid8 && cap8 < 4) begin
      pcs8[cap8] = pc8;
      p48[cap8]  = pc4_8;
      i8[cap8]   = inst8;
      cap8++;
    end
  end

  initial begin
    bit ok;
    // Reset and zero-wait streaming.
    n_ready = 1'b1; n_gnt = 1'b1; lat = 1;
    do_reset(2);
    emitted.delete();
    step();
    chk("post-reset out_valid", 32'(out_valid), 32'h0);
    chk("post-reset out_pc", out_pc, 32'h0);
    chk("post-reset out_inst", out_inst, 32'h0);
    chk("post-reset out_pc_mais_4", out_pc_mais_4, 32'h0);
    chk("first mem_req", 32'(mem_req), 32'h1);
    chk("first mem_addr", mem_addr, 32'h0);
    step();
    step();
    chk("cycle2 out_valid", 32'(out_valid), 32'h1);
    chk("cycle2 out_pc", out_pc, 32'h0);
    chk("cycle2 out_inst", out_inst, 32'hC0DE_0000);
    chk("cycle2 out_pc_mais_4", out_pc_mais_4, 32'h4);
    repeat (18) step();
    expect_seq("stream order", 32'h0, 4);
    chk("stream throughput", emitted.size(), 32'd19);

    // Stall with out_ready low: credit limit caps requests at DEPTH.
    do_reset(1);
    n_ready = 1'b0; n_issue = 0;
    repeat (10) step();
    chk("stall issue count", n_issue, 32'd4);
    chk("stall mem_req", 32'(mem_req), 32'h0);
    chk("stall out_pc", out_pc, 32'h0);
    n_ready = 1'b1;
    emitted.delete();
    repeat (6) step();
    expect_seq("stall drain", 32'h0, 4);

    // Latency 3, redirect with three requests in flight.
    do_reset(1);
    lat = 3;
    ok = 0;
    for (int unsigned k = 0; k < 20 && !ok; k++) begin
      step();
      ok = (pend.size() == 3);
    end
    if (!ok) timeout("wait 3 in flight");
    n_redirect = 1'b1; n_rpc = 32'h100;
    step();
    n_redirect = 1'b0;
    emitted.delete();
    step();
    chk("redirect mem_req", 32'(mem_req), 32'h1);
    chk("redirect mem_addr", mem_addr, 32'h100);
    for (int unsigned k = 0; k < 20 && emitted.size() == 0; k++) step();
    expect_seq("after redirect", 32'h100, 1);

    // Redirect coincident with a response, then a second redirect.
    do_reset(1);
    lat = 2;
    ok = 0;
    for (int unsigned k = 0; k < 20 && !ok; k++) begin
      step();
      ok = (pend.size() > 0 && pend[0].due <= cyc);
    end
    if (!ok) timeout("wait coincident rvalid");
    n_redirect = 1'b1; n_rpc = 32'h103;
    step();
    n_rpc = 32'h200;
    step();
    n_redirect = 1'b0;
    emitted.delete();
    repeat (30) step();
    expect_seq("double redirect", 32'h200, 4);

    // Randomized traffic.
    for (int unsigned k = 0; k < 1500; k++) begin
      if (k % 100 == 0) lat = $urandom_range(1, 4);
      n_gnt      = ($urandom_range(0, 3) != 0);
      n_ready    = ($urandom_range(0, 3) != 0);
      n_redirect = ($urandom_range(0, 39) == 0);
      n_rpc      = $urandom;
      step();
    end
    n_redirect = 1'b0;

    // Reset mid-stream with three queued entries.
    do_reset(1);
    n_ready = 1'b0; lat = 1;
    ok = 0;
    for (int unsigned k = 0; k < 30 && !ok; k++) begin
      n_gnt = (q_pc.size() + pend.size() < 3);
      step();
      ok = (q_pc.size() == 3 && pend.size() == 0);
    end
    if (!ok) timeout("wait queue of 3");
    n_gnt = 1'b1;
    step();
    chk("pre-reset out_valid", 32'(out_valid), 32'h1);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    chk("mid reset out_valid", 32'(out_valid), 32'h0);
    chk("mid reset mem_req", 32'(mem_req), 32'h1);
    chk("mid reset mem_addr", mem_addr, 32'h0);
    repeat (4) step();

    // Narrow-address wrap.
    if (cap8 < 4) timeout("wrap capture");
    else begin
      chk("wrap pc0", 32'(pcs8[0]), 32'hF8);
      chk("wrap pc1", 32'(pcs8[1]), 32'hFC);
      chk("wrap pc2", 32'(pcs8[2]), 32'h00);
      chk("wrap pc3", 32'(pcs8[3]), 32'h04);
      chk("wrap pc4 at F8", 32'(p48[0]), 32'hFC);
      chk("wrap pc4 at FC", 32'(p48[1]), 32'h00);
      chk("wrap inst", i8[2], 32'h5EED_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
